// File: rtl/led_toggle_bank_pkg.sv
// Shared mode encodings and sizing helpers for the LED toggle bank.
package led_pkg;

    localparam logic [1:0] MODE_FOLLOW = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;

    // Width able to hold the value n itself, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/led_toggle_bank_switch_debouncer.sv
// One switch channel: two-flop synchroniser, persistence debouncer and press-edge detector.
module switch_debouncer
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int              CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_stable;
    logic          r_stableD;
    logic [CW-1:0] r_cnt;

    // Counter only runs while the synchronised level disagrees with the accepted one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_stable  <= 1'b0;
            r_stableD <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_s1      <= raw;
            r_s2      <= r_s1;
            r_stableD <= r_stable;
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign stable = r_stable;
    assign press  = r_stable & ~r_stableD;

endmodule

// File: rtl/led_toggle_bank.sv
// Multi-channel switch-to-LED bank with follow, toggle, blink-toggle and off modes.
module led_toggle_bank
    import led_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BLINK_HALF      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] switch,
    input  logic [1:0]      mode,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] press
);

    localparam int            BW    = cnt_width(BLINK_HALF);
    localparam logic [BW-1:0] BLAST = BW'(BLINK_HALF - 1);

    logic [N_CH-1:0] w_stable;
    logic [N_CH-1:0] w_press;
    logic [N_CH-1:0] w_ledNext;
    logic [N_CH-1:0] r_tog;
    logic [N_CH-1:0] r_led;
    logic [BW-1:0]   r_bcnt;
    logic            r_phase;

    for (genvar g = 0; g < N_CH; g++) begin : gen_ch
        switch_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (switch[g]),
            .stable (w_stable[g]),
            .press  (w_press[g])
        );
    end

    // Toggle state tracks presses in every mode so switching modes never loses it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tog <= '0;
        end else begin
            r_tog <= r_tog ^ w_press;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (r_bcnt == BLAST) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt <= r_bcnt + BW'(1);
        end
    end

    always_comb begin
        w_ledNext = '0;
        case (mode)
            MODE_FOLLOW: w_ledNext = w_stable;
            MODE_TOGGLE: w_ledNext = r_tog;
            MODE_BLINK:  w_ledNext = r_tog & {N_CH{r_phase}};
            default:     w_ledNext = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led <= '0;
        end else begin
            r_led <= w_ledNext;
        end
    end

    assign led   = r_led;
    assign press = w_press;

endmodule
